// File: rtl/mem_arbiter_if.sv
// Request/grant and address buses shared between the compute engines and mem_arbiter.
interface mem_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int LANES   = 8,
  parameter int CADDR_W = 16,
  parameter int MADDR_W = 17
);
  logic [NREQ-1:0]               req;
  logic [NREQ-1:0]               rel;
  logic [NREQ*LANES*CADDR_W-1:0] cmem_addr_in;
  logic [NREQ*LANES*MADDR_W-1:0] dmem_addr_in;
  logic [NREQ-1:0]               grant;
  logic [LANES*CADDR_W-1:0]      cmem_addr_out;
  logic [LANES*MADDR_W-1:0]      dmem_addr_out;
  logic                          mem_rd_en;
  logic [NREQ-1:0]               rd_valid;
  logic                          busy;

  modport master (
    output req, rel, cmem_addr_in, dmem_addr_in,
    input  grant, cmem_addr_out, dmem_addr_out, mem_rd_en, rd_valid, busy
  );

  modport slave (
    input  req, rel, cmem_addr_in, dmem_addr_in,
    output grant, cmem_addr_out, dmem_addr_out, mem_rd_en, rd_valid, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin ownership arbiter for the shared config/data memory read ports.
// Optional macro MEMARB_PRIO0_EN: requester 0 (rcal) wins every arbitration and has no hold timeout.
module mem_arbiter #(
  parameter int NREQ     = 4,
  parameter int LANES    = 8,
  parameter int CADDR_W  = 16,
  parameter int MADDR_W  = 17,
  parameter int RD_LAT   = 1,
  parameter int HOLD_MAX = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HC_W   = $clog2(HOLD_MAX + 1);
  localparam int CBUS_W = LANES * CADDR_W;
  localparam int DBUS_W = LANES * MADDR_W;

  typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t             state_r, state_s;
  logic [PTR_W-1:0]   owner_r, owner_s, rr_ptr_r, rr_ptr_s, pick_s, next_ptr_s;
  logic [HC_W-1:0]    hold_cnt_r, hold_cnt_s;
  logic               pick_found_s, owner_req_s, owner_rel_s, timeout_s, end_own_s, own_s;
  logic               mem_rd_en_s;
  logic [NREQ-1:0]    grant_s, rd_valid_s;
  logic [CBUS_W-1:0]  cmem_addr_s;
  logic [DBUS_W-1:0]  dmem_addr_s;
  logic               vld_pipe_r [RD_LAT];
  logic [PTR_W-1:0]   tag_pipe_r [RD_LAT];

  // First requesting index at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    logic [PTR_W-1:0] idx;
    pick_found_s = 1'b0;
    pick_s       = '0;
    idx          = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PTR_W'((int'(rr_ptr_r) + i) % NREQ);
      if (!pick_found_s && bus.req[idx]) begin
        pick_found_s = 1'b1;
        pick_s       = idx;
      end else begin
        pick_s = pick_s;
      end
    end
`ifdef MEMARB_PRIO0_EN
    if (bus.req[0]) begin
      pick_found_s = 1'b1;
      pick_s       = '0;
    end else begin
      pick_s = pick_s;
    end
`endif
  end

  // Owner's own request/release bits decide when ownership ends.
  always_comb begin
    own_s       = (state_r == OWN);
    owner_req_s = bus.req[owner_r];
    owner_rel_s = bus.rel[owner_r];
`ifdef MEMARB_PRIO0_EN
    timeout_s   = (hold_cnt_r == HC_W'(HOLD_MAX - 1)) && (owner_r != '0);
`else
    timeout_s   = (hold_cnt_r == HC_W'(HOLD_MAX - 1));
`endif
    end_own_s   = owner_rel_s || !owner_req_s || timeout_s;
    mem_rd_en_s = own_s && owner_req_s;
    if (owner_r == PTR_W'(NREQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_r + PTR_W'(1);
    end
  end

  // Next-state logic: ownership, hold counter and round-robin pointer.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    rr_ptr_s   = rr_ptr_r;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_s    = OWN;
          owner_s    = pick_s;
          hold_cnt_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      OWN: begin
        if (end_own_s) begin
          state_s    = IDLE;
          hold_cnt_s = '0;
`ifdef MEMARB_PRIO0_EN
          if (owner_r != '0) begin
            rr_ptr_s = next_ptr_s;
          end else begin
            rr_ptr_s = rr_ptr_r;
          end
`else
          rr_ptr_s = next_ptr_s;
`endif
        end else begin
          hold_cnt_s = hold_cnt_r + HC_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      owner_r    <= '0;
      rr_ptr_r   <= '0;
      hold_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      rr_ptr_r   <= rr_ptr_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

  // Read-return pipeline: the owner tag travels with each strobe so later grants cannot disturb it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < RD_LAT; k++) begin
        vld_pipe_r[k] <= 1'b0;
        tag_pipe_r[k] <= '0;
      end
    end else begin
      vld_pipe_r[0] <= mem_rd_en_s;
      tag_pipe_r[0] <= owner_r;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_pipe_r[k] <= vld_pipe_r[k-1];
        tag_pipe_r[k] <= tag_pipe_r[k-1];
      end
    end
  end

  // Grant decode, owner address mux and read-valid decode.
  always_comb begin
    grant_s     = '0;
    rd_valid_s  = '0;
    cmem_addr_s = '0;
    dmem_addr_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (own_s && (owner_r == PTR_W'(i))) begin
        grant_s[i]  = 1'b1;
        cmem_addr_s = bus.cmem_addr_in[i*CBUS_W +: CBUS_W];
        dmem_addr_s = bus.dmem_addr_in[i*DBUS_W +: DBUS_W];
      end else begin
        grant_s[i] = 1'b0;
      end
      if (vld_pipe_r[RD_LAT-1] && (tag_pipe_r[RD_LAT-1] == PTR_W'(i))) begin
        rd_valid_s[i] = 1'b1;
      end else begin
        rd_valid_s[i] = 1'b0;
      end
    end
  end

  assign bus.grant         = grant_s;
  assign bus.busy          = own_s;
  assign bus.mem_rd_en     = mem_rd_en_s;
  assign bus.cmem_addr_out = cmem_addr_s;
  assign bus.dmem_addr_out = dmem_addr_s;
  assign bus.rd_valid      = rd_valid_s;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench: two mem_arbiter instances (RD_LAT=1 and RD_LAT=3) share one stimulus
// and are compared every cycle against an ownership model, plus a few literal expectations.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int NREQ = 4, LANES = 8, CW = 16, DW = 17, HOLD_MAX = 4;
  localparam int CB = LANES * CW, DB = LANES * DW;
`ifdef MEMARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req = '0, rel = '0;
  logic [NREQ*CB-1:0]  cin = '0;
  logic [NREQ*DB-1:0]  din = '0;

  int checks = 0, failures = 0;
  int m_owner = -1, m_rr = 0, m_held = 0, cyc = 0;
  logic [NREQ-1:0] sch1 [16];
  logic [NREQ-1:0] sch3 [16];

  mem_arbiter_if #(.NREQ(NREQ), .LANES(LANES), .CADDR_W(CW), .MADDR_W(DW)) if1 ();
  mem_arbiter_if #(.NREQ(NREQ), .LANES(LANES), .CADDR_W(CW), .MADDR_W(DW)) if3 ();

  assign if1.req = req;  assign if1.rel = rel;
  assign if1.cmem_addr_in = cin;  assign if1.dmem_addr_in = din;
  assign if3.req = req;  assign if3.rel = rel;
  assign if3.cmem_addr_in = cin;  assign if3.dmem_addr_in = din;

  mem_arbiter #(.NREQ(NREQ), .LANES(LANES), .CADDR_W(CW), .MADDR_W(DW),
                .RD_LAT(1), .HOLD_MAX(HOLD_MAX)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  mem_arbiter #(.NREQ(NREQ), .LANES(LANES), .CADDR_W(CW), .MADDR_W(DW),
                .RD_LAT(3), .HOLD_MAX(HOLD_MAX)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_addr();
    for (int k = 0; k < NREQ * CB / 32; k++) cin[k*32 +: 32] = $urandom;
    for (int k = 0; k < NREQ * DB / 32; k++) din[k*32 +: 32] = $urandom;
  endtask

  // Ownership model: one owner at a time, round-robin pick, hold limit, strobes return after RD_LAT.
  always @(negedge clk) begin
    logic [NREQ-1:0] eg, ev1, ev3;
    logic            erd;
    logic [CB-1:0]   ec;
    logic [DB-1:0]   ed;
    int              pick;
    eg = '0; ev1 = '0; ev3 = '0; erd = 1'b0; ec = '0; ed = '0; pick = -1;
    if (reset === 1'b1) begin
      m_owner = -1; m_rr = 0; m_held = 0;
      for (int k = 0; k < 16; k++) begin
        sch1[k] = '0;
        sch3[k] = '0;
      end
    end else begin
      if (m_owner >= 0) begin
        eg[m_owner] = 1'b1;
        erd = req[m_owner];
        ec  = cin[m_owner*CB +: CB];
        ed  = din[m_owner*DB +: DB];
      end
      ev1 = sch1[cyc % 16];  sch1[cyc % 16] = '0;
      ev3 = sch3[cyc % 16];  sch3[cyc % 16] = '0;
    end

    cmp("grant_l1",    144'(if1.grant),         144'(eg));
    cmp("grant_l3",    144'(if3.grant),         144'(eg));
    cmp("busy_l1",     144'(if1.busy),          144'(m_owner >= 0));
    cmp("rd_en_l1",    144'(if1.mem_rd_en),     144'(erd));
    cmp("rd_en_l3",    144'(if3.mem_rd_en),     144'(erd));
    cmp("cmem_l1",     144'(if1.cmem_addr_out), 144'(ec));
    cmp("dmem_l1",     144'(if1.dmem_addr_out), 144'(ed));
    cmp("dmem_l3",     144'(if3.dmem_addr_out), 144'(ed));
    cmp("rd_valid_l1", 144'(if1.rd_valid),      144'(ev1));
    cmp("rd_valid_l3", 144'(if3.rd_valid),      144'(ev3));

    if (reset !== 1'b1) begin
      if (erd) begin
        sch1[(cyc + 1) % 16][m_owner] = 1'b1;
        sch3[(cyc + 3) % 16][m_owner] = 1'b1;
      end
      if (m_owner < 0) begin
        for (int i = 0; i < NREQ; i++)
          if (pick < 0 && req[(m_rr + i) % NREQ]) pick = (m_rr + i) % NREQ;
        if (PRIO0 && req[0]) pick = 0;
        if (pick >= 0) begin
          m_owner = pick;
          m_held  = 0;
        end
      end else begin
        m_held++;
        if (rel[m_owner] || !req[m_owner] || (m_held == HOLD_MAX && !(PRIO0 && m_owner == 0))) begin
          if (!(PRIO0 && m_owner == 0)) m_rr = (m_owner + 1) % NREQ;
          m_owner = -1;
        end
      end
    end
    cyc++;
  end

  initial begin
    rand_addr();
    repeat (2) step();
    req = 4'b1111;
    @(negedge clk);
    cmp("rst_grant",    144'(if1.grant),         144'(4'b0000));
    cmp("rst_rd_en",    144'(if1.mem_rd_en),     144'(1'b0));
    cmp("rst_rd_valid", 144'(if3.rd_valid),      144'(4'b0000));
    cmp("rst_cmem",     144'(if1.cmem_addr_out), 144'(0));
    step(); reset = 1'b0;
    @(negedge clk); cmp("post_rst_no_grant", 144'(if1.grant), 144'(4'b0000));
    step();
    @(negedge clk); cmp("post_rst_grant0", 144'(if1.grant), 144'(4'b0001));
    step(); req = 4'b0000;
    step();
    // Single request from requester 1 with a known lane-0 config address.
    step(); req = 4'b0010; cin[CB +: CW] = 16'h0010;
    @(negedge clk); cmp("single_t_grant", 144'(if1.grant), 144'(4'b0000));
    step();
    @(negedge clk);
    cmp("single_grant1", 144'(if1.grant), 144'(4'b0010));
    cmp("single_lane0",  144'(if1.cmem_addr_out[CW-1:0]), 144'(16'h0010));
    cmp("single_rd_en1", 144'(if1.mem_rd_en), 144'(1'b1));
    step(); rel = 4'b0010;
    @(negedge clk);
    cmp("single_grant2", 144'(if1.grant), 144'(4'b0010));
    cmp("single_rdv_a",  144'(if1.rd_valid), 144'(4'b0010));
    step(); req = 4'b0000; rel = 4'b0000;
    @(negedge clk);
    cmp("single_grant_off", 144'(if1.grant), 144'(4'b0000));
    cmp("single_rdv_b",     144'(if1.rd_valid), 144'(4'b0010));
    cmp("single_rd_en_off", 144'(if1.mem_rd_en), 144'(1'b0));
    step();
    @(negedge clk);
    cmp("single_rdv_end", 144'(if1.rd_valid), 144'(4'b0000));
    cmp("lat3_rdv_a",     144'(if3.rd_valid), 144'(4'b0010));
    step();
    @(negedge clk); cmp("lat3_rdv_b", 144'(if3.rd_valid), 144'(4'b0010));
    step();
    @(negedge clk); cmp("lat3_rdv_end", 144'(if3.rd_valid), 144'(4'b0000));
    // All requesting with rr_ptr at 2.
    step(); req = 4'b1111;
    @(negedge clk); cmp("rr_idle", 144'(if1.grant), 144'(4'b0000));
    step();
`ifdef MEMARB_PRIO0_EN
    @(negedge clk); cmp("rr_first_owner", 144'(if1.grant), 144'(4'b0001));
`else
    @(negedge clk); cmp("rr_first_owner", 144'(if1.grant), 144'(4'b0100));
    repeat (3) step();
    @(negedge clk); cmp("rr_own2_last", 144'(if1.grant), 144'(4'b0100));
    step();
    @(negedge clk); cmp("rr_bubble", 144'(if1.grant), 144'(4'b0000));
    step();
    @(negedge clk); cmp("rr_own3", 144'(if1.grant), 144'(4'b1000));
`endif
    repeat (20) step();
    // Random traffic with occasional reset pulses.
    for (int n = 0; n < 1500; n++) begin
      step();
      reset = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < NREQ; k++) begin
        req[k] = ($urandom_range(0, 9) < ((n < 750) ? 9 : 6));
        rel[k] = ($urandom_range(0, 9) == 0);
      end
      rand_addr();
    end
    step(); reset = 1'b0; req = '0; rel = '0;
    repeat (6) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
